// File: rtl/lpf32_abs.sv
// Four-tap moving-average low-pass filter on a 32-bit signed stream, plus an
// independent combinational saturating absolute-value path.
module lpf32_abs (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic signed [31:0] i_data,
  output logic signed [31:0] o_mean,
  input  logic signed [31:0] i_number,
  output logic signed [31:0] o_number
);

  localparam int DATA_W = 32;
  localparam int SUM_W  = DATA_W + 2;

  logic signed [DATA_W-1:0] tap_p0, tap_p1, tap_p2, tap_p3;
  logic signed [SUM_W-1:0]  sum_p0;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{(SUM_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // Arithmetic shift floors toward minus infinity; the quotient of four
  // 32-bit values always fits back into 32 bits, so truncation is lossless.
  function automatic logic signed [DATA_W-1:0] mean_floor4(input logic signed [SUM_W-1:0] s);
    return DATA_W'(s >>> 2);
  endfunction

  // The most negative value has no positive counterpart; clamp it.
  function automatic logic signed [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] r;
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (x < 0)
      r = -x;
    else
      r = x;
    return r;
  endfunction

  // Stage p0..p3: sample history, newest in tap_p0
  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      tap_p0 <= '0;
      tap_p1 <= '0;
      tap_p2 <= '0;
      tap_p3 <= '0;
    end else begin
      tap_p3 <= tap_p2;
      tap_p2 <= tap_p1;
      tap_p1 <= tap_p0;
      tap_p0 <= i_data;
    end
  end

  always_comb begin
    sum_p0 = sext(tap_p0) + sext(tap_p1) + sext(tap_p2) + sext(tap_p3);
    o_mean = mean_floor4(sum_p0);
  end

  assign o_number = abs_sat(i_number);

endmodule

// File: tb/tb_lpf32_abs.sv
// Directed bench for lpf32_abs: moving-average filter and saturating abs path.
module tb_lpf32_abs;

  logic               i_clock;
  logic               i_RESET;
  logic signed [31:0] i_data;
  logic signed [31:0] o_mean;
  logic signed [31:0] i_number;
  logic signed [31:0] o_number;

  int n_checks;
  int n_errors;

  lpf32_abs dut (
    .i_clock (i_clock),
    .i_RESET (i_RESET),
    .i_data  (i_data),
    .o_mean  (o_mean),
    .i_number(i_number),
    .o_number(o_number)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one rising edge with the given sample, then settle to the falling edge.
  task automatic step(input logic signed [31:0] d);
    i_data = d;
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  // Asynchronous reset pulse placed entirely between clock edges.
  task automatic rst_pulse();
    @(negedge i_clock);
    i_RESET = 1'b1;
    #1;
    chk("rst_async_mean", o_mean, 32'sd0);
    #1;
    i_RESET = 1'b0;
    #1;
    chk("rst_after_release", o_mean, 32'sd0);
  endtask

  initial begin
    logic signed [31:0] step_exp[6];
    logic signed [31:0] neg_exp[4];
    logic signed [31:0] abs_in[5];
    logic signed [31:0] abs_exp[5];
    step_exp = '{32'sd25, 32'sd50, 32'sd75, 32'sd100, 32'sd100, 32'sd100};
    neg_exp  = '{-32'sd2, -32'sd3, -32'sd4, -32'sd5};
    abs_in   = '{32'sd123, -32'sd7, 32'sd0, 32'sh8000_0000, 32'shFFFF_FFFF};
    abs_exp  = '{32'sd123, 32'sd7, 32'sd0, 32'sh7FFF_FFFF, 32'sd1};
    n_checks = 0;
    n_errors = 0;

    // Reset held with a nonzero sample and a running clock
    i_RESET  = 1'b1;
    i_data   = 32'sd1234;
    i_number = 32'sd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clock);
      chk("reset_hold_mean", o_mean, 32'sd0);
    end

    // Absolute value path, exercised while reset is asserted
    for (int i = 0; i < 5; i++) begin
      i_number = abs_in[i];
      #1;
      chk("abs_in_reset", o_number, abs_exp[i]);
    end

    // Step response of 100
    @(negedge i_clock);
    i_RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(32'sd100);
      chk("step_100", o_mean, step_exp[i]);
    end

    // Negative rounding toward minus infinity
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      step(-32'sd5);
      chk("neg_floor", o_mean, neg_exp[i]);
    end

    // Positive extreme
    rst_pulse();
    for (int i = 0; i < 4; i++) step(32'sh7FFF_FFFF);
    chk("max_full", o_mean, 32'sh7FFF_FFFF);

    // Negative extreme
    rst_pulse();
    for (int i = 0; i < 4; i++) step(32'sh8000_0000);
    chk("min_full", o_mean, 32'sh8000_0000);

    // Alternating extremes: sum is -2, floor(-2/4) = -1
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000);
      if (i >= 3) chk("alt_extremes", o_mean, -32'sd1);
    end

    // Mid-stream reset discards history immediately
    rst_pulse();
    for (int i = 0; i < 3; i++) step(32'sd100);
    chk("pre_mid_reset", o_mean, 32'sd75);
    rst_pulse();
    step(32'sd100);
    chk("post_mid_reset", o_mean, 32'sd25);

    // Absolute value path during normal operation
    for (int i = 0; i < 5; i++) begin
      i_number = abs_in[4 - i];
      #1;
      chk("abs_running", o_number, abs_exp[4 - i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lpf32_abs.md
LPF32_ABS -- requirements
Module: lpf32_abs

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, averaging window fixed at 4 samples.
REQ-002 One clock; reset is asynchronous and active-high (i_clock, i_RESET).
REQ-003 i_clock  input  1  rising-edge clock for the filter path.
REQ-004 i_RESET  input  1  asynchronous active-high reset; clears the filter history.
REQ-005 i_data  input  32  signed two's-complement sample to be averaged.
REQ-006 o_mean  output  32  signed moving average of the last 4 registered samples.
REQ-007 i_number  input  32  signed operand for the absolute-value path.
REQ-008 o_number  output  32  absolute value of i_number.

Function
REQ-009 Filter history SHALL be a 4-entry shift register of 32-bit signed taps, t0 newest to t3 oldest.
REQ-010 On every rising i_clock edge with i_RESET low: t3<=t2, t2<=t1, t1<=t0, t0<=i_data.
REQ-011 o_mean SHALL be combinational from the taps: floor((t0+t1+t2+t3)/4).
REQ-012 The sum SHALL be computed sign-extended to at least 34 bits, with no intermediate overflow.
REQ-013 The divide SHALL be an arithmetic right shift by 2 (rounds toward minus infinity); the result always fits 32 bits.
REQ-014 Latency: a sample presented before edge k contributes to o_mean immediately after edge k; full weight after edge k+3.
REQ-015 No enable or valid handshake; a new sample is taken every clock.
REQ-016 The absolute-value path SHALL be purely combinational and independent of clock and reset.
REQ-017 o_number = i_number when i_number >= 0, otherwise the two's-complement negation of i_number.
REQ-018 i_number = 0x80000000 SHALL saturate to o_number = 0x7FFFFFFF.
REQ-019 No X propagation from the taps after reset; the outputs never depend on uninitialised state once reset has been applied.

Reset
REQ-020 While i_RESET is high, all taps SHALL be 0 asynchronously, so o_mean = 0.
REQ-021 Reset asserted mid-stream SHALL discard all history immediately, regardless of the clock.
REQ-022 After reset deasserts, the first rising edge loads t0; the other taps remain 0 until filled.
REQ-023 o_number SHALL be unaffected by i_RESET.

Verification
REQ-024 Reset: assert i_RESET with i_data=1234 and clock running -> o_mean = 0 throughout.
REQ-025 Step: after reset, i_data=100 constant -> o_mean = 25, 50, 75, 100 after edges 1..4, then stays 100.
REQ-026 Negative rounding: after reset, i_data=-5 constant -> o_mean = -2, -3, -4, -5 after edges 1..4.
REQ-027 Range extremes:
- four samples of 0x7FFFFFFF -> o_mean = 0x7FFFFFFF.
- four samples of 0x80000000 -> o_mean = 0x80000000.
- alternating 0x7FFFFFFF / 0x80000000 -> o_mean = -1 once the window is full.
REQ-028 Mid-operation reset: after 3 samples of 100, pulse i_RESET between edges -> o_mean drops to 0 immediately; the next edge with i_data=100 gives 25.
REQ-029 Absolute value: i_number = 123, -7, 0, 0x80000000, 0xFFFFFFFF -> o_number = 123, 7, 0, 0x7FFFFFFF, 1.
